// File: rtl/hw_pwm_detect_pkg.sv
// hwdet_pkg: shared FSM state type, counter limits and synchronizer depth check
package hwdet_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic bit sync_ok(input int n);
    return n >= SYNC_MIN && n <= SYNC_MAX;
  endfunction
endpackage

// File: rtl/hw_pwm_detect_if.sv
// hw_pwm_detect_if: PWM input, enable and published measurement bundle
interface hw_pwm_detect_if #(parameter int CNT_WIDTH = 32);
  logic                 enable;
  logic                 pwm_in;
  logic [CNT_WIDTH-1:0] high_count;
  logic [CNT_WIDTH-1:0] low_count;
  logic [CNT_WIDTH:0]   period;
  logic                 meas_valid;
  logic                 stuck;
  logic                 stuck_level;
  modport master (
    output enable, pwm_in,
    input  high_count, low_count, period, meas_valid, stuck, stuck_level
  );
  modport slave (
    input  enable, pwm_in,
    output high_count, low_count, period, meas_valid, stuck, stuck_level
  );
endinterface

// File: rtl/hw_pwm_detect_sync.sv
// pwm_in_sync: multi-flop synchronizer for pwm_in with registered level and edge strobes
module pwm_in_sync #(
  parameter int STAGES = 2
) (
  input  logic sysclk,
  input  logic sysreset_n,
  input  logic pwm_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q, rise_q, fall_q;
  // shift pwm_in through the chain; prev_q holds the last synchronized level so rise/fall line up with it
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end
  assign sync_o = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/hw_pwm_detect.sv
// hw_pwm_detect: measures PWM high/low time per full period and flags a stuck line
module hw_pwm_detect
  import hwdet_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input logic           sysclk,
  input logic           sysreset_n,
  hw_pwm_detect_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] TMO     = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("hw_pwm_detect: SYNC_STAGES must be within 2..4");
  end
  logic                 sync, rise, fall;
  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hi_pend_q, high_q, low_q;
  logic [CNT_WIDTH:0]   period_q, period_d;
  logic                 meas_valid_q, stuck_q, stuck_level_q;
  pwm_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .pwm_i      (bus.pwm_in),
    .sync_o     (sync),
    .rise_o     (rise),
    .fall_o     (fall)
  );
  assign cnt_d    = (rise | fall) ? ONE : (cnt_q == CNT_MAX ? cnt_q : cnt_q + ONE);
  assign period_d = {1'b0, hi_pend_q} + {1'b0, cnt_q};
  // level counter, period FSM, capture and stuck detection; an edge beats a timeout in the same cycle
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_pend_q     <= '0;
      high_q        <= '0;
      low_q         <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else if (!bus.enable) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      meas_valid_q <= 1'b0;
      if (rise) begin
        stuck_q       <= 1'b0;
        stuck_level_q <= 1'b0;
        state_q       <= ST_HIGH;
        if (state_q == ST_LOW) begin
          high_q       <= hi_pend_q;
          low_q        <= cnt_q;
          period_q     <= period_d;
          meas_valid_q <= 1'b1;
        end
      end else if (fall) begin
        stuck_level_q <= 1'b0;
        if (state_q == ST_HIGH) begin
          hi_pend_q <= cnt_q;
          state_q   <= ST_LOW;
        end
      end else if (cnt_q == TMO) begin
        stuck_q       <= 1'b1;
        stuck_level_q <= sync;
        state_q       <= ST_IDLE;
      end
    end
  end
  assign bus.high_count  = high_q;
  assign bus.low_count   = low_q;
  assign bus.period      = period_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;
endmodule

// File: tb/tb_hw_pwm_detect.sv
// tb_hw_pwm_detect: scoreboard bench for hw_pwm_detect with a reduced stuck timeout
module tb_hw_pwm_detect;
  typedef struct {logic [31:0] h; logic [31:0] l;} exp_t;
  typedef enum {M_IDLE, M_HIGH, M_LOW} mst_t;
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint last_v = 0;
  longint stuck_t = 0;
  int     gap_exp = 0;
  bit     gap_seen = 0;
  logic   stuck_prev = 1'b0;
  exp_t   q[$];
  mst_t   m_st = M_IDLE;
  logic [31:0] m_h = 0;
  logic [31:0] m_l = 0;
  hw_pwm_detect_if #(.CNT_WIDTH(32)) bus ();
  hw_pwm_detect #(.CNT_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)) dut (
    .sysclk     (clk),
    .sysreset_n (rst_n),
    .bus        (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_outs(input string tag, input logic [31:0] h, input logic [31:0] l,
                            input logic st, input logic sl);
    check({tag, "_high"}, 64'(bus.high_count), 64'(h));
    check({tag, "_low"}, 64'(bus.low_count), 64'(l));
    check({tag, "_period"}, 64'(bus.period), 64'(h) + 64'(l));
    check({tag, "_stuck"}, 64'(bus.stuck), 64'(st));
    check({tag, "_stuck_level"}, 64'(bus.stuck_level), 64'(sl));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.meas_valid) begin
      if (q.size() == 0) check("spurious_valid", 64'(bus.meas_valid), 64'd0);
      else begin
        e = q.pop_front();
        check("sb_high", 64'(bus.high_count), 64'(e.h));
        check("sb_low", 64'(bus.low_count), 64'(e.l));
        check("sb_period", 64'(bus.period), 64'(e.h) + 64'(e.l));
      end
      if (gap_exp != 0) begin
        if (gap_seen) check("valid_gap", 64'(cyc - last_v), 64'(gap_exp));
        gap_seen = 1;
      end
      last_v = cyc;
    end
    if (gap_exp == 0) gap_seen = 0;
    if (bus.stuck && !stuck_prev) stuck_t = cyc;
    stuck_prev = bus.stuck;
  end
  task automatic drive(input logic v, input int n);
    if (v && !bus.pwm_in) begin
      if (m_st == M_LOW) q.push_back('{m_h, m_l});
      m_st = M_HIGH;
      m_h  = 0;
    end else if (!v && bus.pwm_in && m_st == M_HIGH) begin
      m_st = M_LOW;
      m_l  = 0;
    end
    bus.pwm_in = v;
    if (v) m_h += 32'(n);
    else m_l += 32'(n);
    repeat (n) @(negedge clk);
  endtask
  task automatic en_drop(input int n);
    bus.enable = 1'b0;
    repeat (n) @(negedge clk);
    bus.enable = 1'b1;
    m_st = M_IDLE;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);
    check("reset_valid", 64'(bus.meas_valid), 64'd0);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    @(negedge clk);
    drive(0, 20);
    gap_exp = 1000;
    repeat (5) begin
      drive(1, 300);
      drive(0, 700);
    end
    drive(1, 300);
    gap_exp = 0;
    check_outs("steady", 300, 700, 0, 0);
    en_drop(5);
    drive(0, 2);
    gap_exp = 4;
    repeat (6) begin
      drive(1, 2);
      drive(0, 2);
    end
    drive(1, 2);
    drive(0, 10);
    gap_exp = 0;
    check_outs("min", 2, 2, 0, 0);
    en_drop(5);
    drive(0, 10);
    drive(1, 100);
    drive(0, 100);
    drive(1, 100);
    drive(0, 100);
    drive(1, 4200);
    check_outs("stuck_hi", 100, 100, 1, 1);
    check("stuck_hi_delay", 64'(stuck_t - last_v), 64'd4096);
    m_st = M_IDLE;
    drive(0, 100);
    drive(1, 100);
    check("stuck_clr_a", 64'(bus.stuck), 64'd0);
    drive(0, 100);
    drive(1, 100);
    drive(0, 4300);
    check_outs("stuck_lo", 100, 100, 1, 0);
    check("stuck_lo_delay", 64'(stuck_t - last_v), 64'd4196);
    m_st = M_IDLE;
    drive(1, 50);
    check_outs("resume_rise", 100, 100, 0, 0);
    drive(0, 150);
    drive(1, 50);
    drive(0, 150);
    check_outs("resume", 50, 150, 0, 0);
    drive(1, 20);
    en_drop(10);
    check_outs("en_held", 50, 150, 0, 0);
    drive(1, 30);
    drive(0, 150);
    drive(1, 50);
    check("en_no_report", 64'(q.size()), 64'd0);
    drive(0, 150);
    drive(1, 50);
    drive(0, 20);
    check("q_empty_pre_rst", 64'(q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid", 0, 0, 0, 0);
    check("rst_mid_valid", 64'(bus.meas_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_st = M_IDLE;
    drive(0, 10);
    drive(1, 300);
    drive(0, 700);
    check_outs("restart_partial", 0, 0, 0, 0);
    drive(1, 300);
    drive(0, 700);
    drive(1, 20);
    drive(0, 10);
    check_outs("restart", 300, 700, 0, 0);
    repeat (10) @(negedge clk);
    check("pending", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
